// File: rtl/sw_seq_feeder.sv
// Loader for the sw Smith-Waterman array: holds packed S/T base memories, streams
// one base pair per cycle on start, then waits for sw.finish and latches the score.
module sw_seq_feeder #(
    parameter int LEN     = 256,
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              start,
    output logic              busy,
    output logic              valid,
    output logic [1:0]        data_s,
    output logic [1:0]        data_t,
    input  logic              sw_finish,
    input  logic [11:0]       sw_max,
    output logic [11:0]       score,
    output logic              done,
    output logic              timeout
);

    localparam int IDX_W  = $clog2(LEN);
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WCNT_W-1:0]  wait_q, wait_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic [1:0]         data_s_q, data_s_d;
    logic [1:0]         data_t_q, data_t_d;
    logic [11:0]        score_q, score_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;

    logic [7:0]         mem_s [2**ADDR_W];
    logic [7:0]         mem_t [2**ADDR_W];
    logic               mem_we;
    logic [IDX_W-1:0]   rd_idx;
    logic [7:0]         rd_byte_s, rd_byte_t;
    logic [1:0]         rd_base_s, rd_base_t;

    // Read port looks one base ahead so the registered data outputs line up with idx.
    assign rd_idx    = (state_q == IDLE) ? '0 : idx_q + IDX_W'(1);
    assign rd_byte_s = mem_s[rd_idx[IDX_W-1:2]];
    assign rd_byte_t = mem_t[rd_idx[IDX_W-1:2]];
    assign rd_base_s = rd_byte_s[{rd_idx[1:0], 1'b0} +: 2];
    assign rd_base_t = rd_byte_t[{rd_idx[1:0], 1'b0} +: 2];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wait_d    = wait_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        data_s_d  = data_s_q;
        data_t_d  = data_t_q;
        score_d   = score_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = STREAM;
                    idx_d     = '0;
                    timeout_d = 1'b0;
                    busy_d    = 1'b1;
                    valid_d   = 1'b1;
                    data_s_d  = rd_base_s;
                    data_t_d  = rd_base_t;
                end else begin
                    mem_we = wr_en;
                end
            end
            STREAM: begin
                if (idx_q == IDX_W'(LEN - 1)) begin
                    state_d  = WAIT;
                    valid_d  = 1'b0;
                    data_s_d = 2'd0;
                    data_t_d = 2'd0;
                    wait_d   = '0;
                end else begin
                    idx_d    = idx_q + IDX_W'(1);
                    data_s_d = rd_base_s;
                    data_t_d = rd_base_t;
                end
            end
            WAIT: begin
                // A finish on the final wait cycle beats the timeout.
                if (sw_finish) begin
                    state_d = IDLE;
                    score_d = sw_max;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (wait_q == WCNT_W'(TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    score_d   = 12'd0;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    wait_d = wait_q + WCNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            wait_q    <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_s_q  <= 2'd0;
            data_t_q  <= 2'd0;
            score_q   <= 12'd0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            data_s_q  <= data_s_d;
            data_t_q  <= data_t_d;
            score_q   <= score_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    // Base memories keep their contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (wr_sel) begin
                mem_t[wr_addr] <= wr_data;
            end else begin
                mem_s[wr_addr] <= wr_data;
            end
        end
    end

    assign busy    = busy_q;
    assign valid   = valid_q;
    assign data_s  = data_s_q;
    assign data_t  = data_t_q;
    assign score   = score_q;
    assign done    = done_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_sw_seq_feeder.sv
// Self-checking bench for sw_seq_feeder: a base-array model of both memories
// plus a behavioural sw stand-in that raises finish after a chosen delay.
module tb_sw_seq_feeder;

    localparam int LEN     = 256;
    localparam int ADDR_W  = 6;
    localparam int TIMEOUT = 1023;
    localparam int NBYTES  = LEN / 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic              wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              start;
    logic              busy;
    logic              valid;
    logic [1:0]        data_s;
    logic [1:0]        data_t;
    logic              sw_finish;
    logic [11:0]       sw_max;
    logic [11:0]       score;
    logic              done;
    logic              timeout;

    int checks = 0;
    int errors = 0;

    logic [1:0] s_ref [LEN];
    logic [1:0] t_ref [LEN];

    sw_seq_feeder #(.LEN(LEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .busy(busy),
        .valid(valid), .data_s(data_s), .data_t(data_t), .sw_finish(sw_finish),
        .sw_max(sw_max), .score(score), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Host byte write; the model stores base 4*addr+k from bits [2k+1:2k].
    task automatic write_byte(input bit sel, input int addr, input logic [7:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_addr = ADDR_W'(addr); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (sel) t_ref[4*addr + k] = d[2*k +: 2];
            else     s_ref[4*addr + k] = d[2*k +: 2];
        end
    endtask

    task automatic fill_const(input logic [7:0] ds, input logic [7:0] dt);
        for (int a = 0; a < NBYTES; a++) write_byte(1'b0, a, ds);
        for (int a = 0; a < NBYTES; a++) write_byte(1'b1, a, dt);
    endtask

    task automatic fill_random();
        for (int a = 0; a < NBYTES; a++) write_byte(1'b0, a, 8'($urandom));
        for (int a = 0; a < NBYTES; a++) write_byte(1'b1, a, 8'($urandom));
    endtask

    // Called at a negedge in IDLE; optionally collides a T write with the start.
    task automatic start_run(input bit collide, input logic [7:0] cdata);
        start = 1'b1;
        if (collide) begin
            wr_en = 1'b1; wr_sel = 1'b1; wr_addr = '0; wr_data = cdata;
        end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        checks++;
        if (busy !== 1'b1 || timeout !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_accept: busy=%0b timeout=%0b done=%0b, expected busy=1 timeout=0 done=0",
                     busy, timeout, done);
        end
    endtask

    // Checks every streamed pair; stop_at < LEN leaves the run mid-stream.
    task automatic check_stream(input bit blk_write, input int stop_at);
        for (int i = 0; i < LEN; i++) begin
            if (i == stop_at) begin
                wr_en = 1'b0;
                return;
            end
            checks++;
            if (valid !== 1'b1 || data_s !== s_ref[i] || data_t !== t_ref[i]) begin
                errors++;
                $display("[TB] FAIL stream[%0d]: valid=%0b s=%0d t=%0d, expected valid=1 s=%0d t=%0d",
                         i, valid, data_s, data_t, s_ref[i], t_ref[i]);
            end
            if (blk_write && i >= 4 && i < 8) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 8'hFF;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b1 || data_s !== 2'd0 || data_t !== 2'd0) begin
            errors++;
            $display("[TB] FAIL wait_entry: valid=%0b busy=%0b s=%0d t=%0d, expected valid=0 busy=1 s=0 t=0",
                     valid, busy, data_s, data_t);
        end
    endtask

    // Model sw: finish 'delay' cycles after valid fell; returns at the done cycle.
    task automatic finish_after(input int delay, input logic [11:0] val);
        repeat (delay) @(negedge clk);
        sw_finish = 1'b1; sw_max = val;
        @(negedge clk);
        sw_finish = 1'b0;
        checks++;
        if (done !== 1'b1 || score !== val || busy !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL finish_capture: done=%0b score=%h busy=%0b timeout=%0b, expected done=1 score=%h busy=0 timeout=0",
                     done, score, busy, timeout, val);
        end
    endtask

    task automatic check_done_drop(input logic [11:0] val);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || score !== val) begin
            errors++;
            $display("[TB] FAIL done_pulse: done=%0b score=%h, expected done=0 score=%h", done, score, val);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; sw_finish = 1'b0; sw_max = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, valid, data_s, data_t, score, done, timeout} !== 20'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: busy=%0b valid=%0b s=%0d t=%0d score=%h done=%0b timeout=%0b, expected all 0",
                     busy, valid, data_s, data_t, score, done, timeout);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        fill_const(8'h1B, 8'hE4);
        start_run(1'b0, 8'h00);
        check_stream(1'b0, LEN);
        finish_after(40, 12'h0A5);
        check_done_drop(12'h0A5);
        sw_finish = 1'b1; sw_max = 12'hFFF;
        @(negedge clk);
        sw_finish = 1'b0;
        checks++;
        if (done !== 1'b0 || score !== 12'h0A5 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_finish_ignored: done=%0b score=%h busy=%0b, expected done=0 score=0a5 busy=0",
                     done, score, busy);
        end
    endtask

    task automatic test_write_block();
        start_run(1'b0, 8'h00);
        check_stream(1'b1, LEN);
        finish_after($urandom_range(1, 200), 12'h123);
        check_done_drop(12'h123);
        start_run(1'b0, 8'h00);
        check_stream(1'b0, LEN);
        finish_after(5, 12'h321);
        check_done_drop(12'h321);
    endtask

    task automatic test_collision();
        start_run(1'b1, ~{t_ref[3], t_ref[2], t_ref[1], t_ref[0]});
        check_stream(1'b0, LEN);
        finish_after(3, 12'h7E1);
        check_done_drop(12'h7E1);
    endtask

    task automatic test_timeout();
        int n;
        fill_random();
        start_run(1'b0, 8'h00);
        check_stream(1'b0, LEN);
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != TIMEOUT || score !== 12'd0 || timeout !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_run: cycles=%0d score=%h timeout=%0b busy=%0b, expected cycles=%0d score=0 timeout=1 busy=0",
                     n, score, timeout, busy, TIMEOUT);
        end
        @(negedge clk);
    endtask

    task automatic test_tie();
        logic [11:0] v;
        v = 12'($urandom_range(1, 4095));
        start_run(1'b0, 8'h00);
        check_stream(1'b0, LEN);
        finish_after(TIMEOUT - 1, v);
        check_done_drop(v);
    endtask

    task automatic test_reset_mid();
        start_run(1'b0, 8'h00);
        check_stream(1'b0, 100);
        reset = 1'b1;
        #1;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || data_s !== 2'd0 || data_t !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid: valid=%0b busy=%0b s=%0d t=%0d, expected all 0", valid, busy, data_s, data_t);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start_run(1'b0, 8'h00);
        check_stream(1'b0, LEN);
        finish_after(10, 12'h0F0);
        check_done_drop(12'h0F0);
    endtask

    task automatic test_back_to_back();
        logic [11:0] v;
        for (int r = 0; r < 3; r++) begin
            v = 12'($urandom);
            fill_random();
            start_run(1'b0, 8'h00);
            check_stream(1'b0, LEN);
            finish_after($urandom_range(0, 900), v);
            start_run(1'b0, 8'h00);
            check_stream(1'b0, LEN);
            finish_after($urandom_range(0, 900), v ^ 12'h5A5);
            check_done_drop(v ^ 12'h5A5);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_write_block();
        test_collision();
        test_timeout();
        test_tie();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
